// File: rtl/dsi_packet_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : dsi_packet_sequencer
// Purpose : Emits one DSI packet per command: header, long payload and a
//           CRC footer on a 32-bit byte-lane stream. DSI_SEQ_STATS_EN adds
//           packet and byte counters.
// Revision: 1.0 - initial release
// ============================================================================
module dsi_packet_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_data_id,
    input  logic        cmd_long,
    input  logic [15:0] cmd_wc,
    input  logic        pld_valid,
    output logic        pld_ready,
    input  logic [31:0] pld_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [1:0]  out_bytes,
    output logic        out_last,
    output logic [23:0] ecc_hdr,
    input  logic [7:0]  ecc_value,
    output logic        crc_clear,
    output logic        crc_write,
    output logic [1:0]  crc_bytes,
    output logic [31:0] crc_data,
    input  logic [15:0] crc_value,
`ifdef DSI_SEQ_STATS_EN
    output logic [15:0] pkt_cnt,
    output logic [31:0] byte_cnt,
`endif
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_PLD  = 2'd2,
        S_FTR  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_cmd_ready;
    logic        r_crc_clear;
    logic [7:0]  r_id;
    logic [15:0] r_wc;
    logic        r_long;
    logic [15:0] r_rem;

    logic [1:0]  w_pld_bytes;
    logic [15:0] w_step;
    logic        w_beat;

    // Final word may be partial; upper lanes beyond the word count are ignored.
    assign w_pld_bytes = (r_rem >= 16'd4) ? 2'd3 : (r_rem[1:0] - 2'd1);
    assign w_step      = {14'd0, w_pld_bytes} + 16'd1;
    assign w_beat      = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_crc_clear <= 1'b0;
            r_id        <= 8'd0;
            r_wc        <= 16'd0;
            r_long      <= 1'b0;
            r_rem       <= 16'd0;
        end else begin
            r_crc_clear <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (cmd_valid && r_cmd_ready) begin
                        r_id        <= cmd_data_id;
                        r_wc        <= cmd_wc;
                        r_long      <= cmd_long;
                        r_rem       <= cmd_wc;
                        r_cmd_ready <= 1'b0;
                        r_crc_clear <= 1'b1;
                        r_state     <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (out_ready) begin
                        if (!r_long) begin
                            r_state     <= S_IDLE;
                            r_cmd_ready <= 1'b1;
                        end else if (r_wc == 16'd0) begin
                            r_state <= S_FTR;
                        end else begin
                            r_state <= S_PLD;
                        end
                    end
                end
                S_PLD: begin
                    if (w_beat) begin
                        r_rem <= r_rem - w_step;
                        if (r_rem <= 16'd4) begin
                            r_state <= S_FTR;
                        end
                    end
                end
                S_FTR: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Payload is a zero-latency passthrough, so the beat outputs are decoded from state.
    always_comb begin
        out_valid = 1'b0;
        out_data  = 32'd0;
        out_bytes = 2'd0;
        out_last  = 1'b0;
        pld_ready = 1'b0;
        crc_write = 1'b0;
        crc_bytes = 2'd0;
        crc_data  = 32'd0;
        case (r_state)
            S_HDR: begin
                out_valid = 1'b1;
                // The top two parity bits of the ECC byte are always zero on the wire.
                out_data  = {ecc_value[7:6] & 2'b00, ecc_value[5:0], r_wc, r_id};
                out_bytes = 2'd3;
                out_last  = ~r_long;
            end
            S_PLD: begin
                out_valid = pld_valid;
                out_data  = pld_data;
                out_bytes = w_pld_bytes;
                pld_ready = out_ready;
                crc_write = pld_valid & out_ready;
                crc_bytes = w_pld_bytes;
                crc_data  = pld_data;
            end
            S_FTR: begin
                out_valid = 1'b1;
                out_data  = {16'h0000, crc_value};
                out_bytes = 2'd1;
                out_last  = 1'b1;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    assign cmd_ready = r_cmd_ready;
    assign crc_clear = r_crc_clear;
    assign ecc_hdr   = {r_wc, r_id};
    assign busy      = (r_state != S_IDLE);

`ifdef DSI_SEQ_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_cnt  <= 16'd0;
            byte_cnt <= 32'd0;
        end else if (w_beat) begin
            byte_cnt <= byte_cnt + {30'd0, out_bytes} + 32'd1;
            if (out_last) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
